// File: rtl/pong_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pong_pkg : shared state encoding and timer sizing for pong_game_ctrl       |
// | Rev 1.0  : initial release                                                 |
// +----------------------------------------------------------------------------+
package pong_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_SERVE = 3'd1,
        SERVE      = 3'd2,
        PLAY       = 3'd3,
        POINT      = 3'd4,
        GAME_OVER  = 3'd5
    } game_state_t;

    localparam int SERVE_HOLD_DFLT       = 4;
    localparam int POINT_DELAY_DFLT      = 60;
    localparam int AUTO_SERVE_TICKS_DFLT = 180;

    // The timer only ever holds values up to (limit - 1).
    function automatic int timer_width(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

    localparam int TIMER_W = timer_width(POINT_DELAY_DFLT, AUTO_SERVE_TICKS_DFLT, SERVE_HOLD_DFLT);

endpackage
`default_nettype wire

// File: rtl/pong_game_ctrl_btn_edge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | btn_edge : 2-flop synchroniser plus one-clk rising-edge pulse              |
// | Rev 1.0  : initial release                                                 |
// +----------------------------------------------------------------------------+
module btn_edge (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic pulse
);

    logic sync1_q, sync2_q, prev_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign pulse = sync2_q & ~prev_q;

endmodule
`default_nettype wire

// File: rtl/pong_game_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pong_game_ctrl : match/serve controller (scores, serve, pause, winner)     |
// | Option macro PONG_AUTO_SERVE_EN enables timed automatic serve in WAIT_SERVE|
// | Rev 1.0  : initial release                                                 |
// +----------------------------------------------------------------------------+
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int WIN_SCORE        = 7,
    parameter int SCORE_W          = 4,
    parameter int SERVE_HOLD       = SERVE_HOLD_DFLT,
    parameter int POINT_DELAY      = POINT_DELAY_DFLT,
    parameter int AUTO_SERVE_TICKS = AUTO_SERVE_TICKS_DFLT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               btn_l,
    input  logic               btn_r,
    input  logic               miss_l,
    input  logic               miss_r,
    output logic               srv_l,
    output logic               srv_r,
    output logic [SCORE_W-1:0] score_l,
    output logic [SCORE_W-1:0] score_r,
    output logic               server_r,
    output logic               point_pause,
    output logic               game_over,
    output logic               winner_r
);

    localparam int c_tmr_need = timer_width(POINT_DELAY, AUTO_SERVE_TICKS, SERVE_HOLD);
    localparam int c_tmr_w    = (c_tmr_need > TIMER_W) ? c_tmr_need : TIMER_W;

    localparam logic [SCORE_W-1:0] c_win        = SCORE_W'(WIN_SCORE);
    localparam logic [c_tmr_w-1:0] c_hold_last  = c_tmr_w'(SERVE_HOLD - 1);
    localparam logic [c_tmr_w-1:0] c_delay_last = c_tmr_w'(POINT_DELAY - 1);
`ifdef PONG_AUTO_SERVE_EN
    localparam logic [c_tmr_w-1:0] c_auto_last  = c_tmr_w'(AUTO_SERVE_TICKS - 1);
`endif

    game_state_t        state_q, state_d;
    logic [c_tmr_w-1:0] timer_q, timer_d;
    logic [SCORE_W-1:0] score_l_q, score_l_d, score_r_q, score_r_d;
    logic               server_r_q, server_r_d;
    logic               miss_l_q, miss_r_q, miss_l_prev_q, miss_r_prev_q;
    logic               w_btn_l_pulse, w_btn_r_pulse, w_any_btn;
    logic               w_miss_l_edge, w_miss_r_edge;

    btn_edge u_btn_l (.clk(clk), .reset(reset), .btn(btn_l), .pulse(w_btn_l_pulse));
    btn_edge u_btn_r (.clk(clk), .reset(reset), .btn(btn_r), .pulse(w_btn_r_pulse));

    assign w_any_btn     = w_btn_l_pulse | w_btn_r_pulse;
    // The ball holds miss high until the next serve, so only the rise counts.
    assign w_miss_l_edge = miss_l_q & ~miss_l_prev_q;
    assign w_miss_r_edge = miss_r_q & ~miss_r_prev_q;

    always_comb begin
        state_d    = state_q;
        timer_d    = en ? timer_q + 1'b1 : timer_q;
        score_l_d  = score_l_q;
        score_r_d  = score_r_q;
        server_r_d = server_r_q;
        case (state_q)
            IDLE: begin
                if (w_any_btn) state_d = WAIT_SERVE;
            end
            WAIT_SERVE: begin
                if (server_r_q ? w_btn_r_pulse : w_btn_l_pulse) state_d = SERVE;
`ifdef PONG_AUTO_SERVE_EN
                else if (en && timer_q == c_auto_last) state_d = SERVE;
`endif
            end
            SERVE: begin
                if (en && timer_q == c_hold_last) state_d = PLAY;
            end
            PLAY: begin
                if (w_miss_l_edge && w_miss_r_edge) begin
                    state_d = POINT;
                end else if (w_miss_l_edge) begin
                    score_r_d  = (score_r_q >= c_win) ? c_win : score_r_q + 1'b1;
                    server_r_d = 1'b0;
                    state_d    = POINT;
                end else if (w_miss_r_edge) begin
                    score_l_d  = (score_l_q >= c_win) ? c_win : score_l_q + 1'b1;
                    server_r_d = 1'b1;
                    state_d    = POINT;
                end
            end
            POINT: begin
                if (en && timer_q == c_delay_last)
                    state_d = (score_l_q == c_win || score_r_q == c_win) ? GAME_OVER : WAIT_SERVE;
            end
            GAME_OVER: begin
                if (w_any_btn) begin
                    score_l_d  = '0;
                    score_r_d  = '0;
                    server_r_d = ~(score_r_q == c_win);
                    state_d    = WAIT_SERVE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (state_d != state_q) timer_d = '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            timer_q       <= '0;
            score_l_q     <= '0;
            score_r_q     <= '0;
            server_r_q    <= 1'b0;
            miss_l_q      <= 1'b0;
            miss_r_q      <= 1'b0;
            miss_l_prev_q <= 1'b0;
            miss_r_prev_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            score_l_q     <= score_l_d;
            score_r_q     <= score_r_d;
            server_r_q    <= server_r_d;
            miss_l_q      <= miss_l;
            miss_r_q      <= miss_r;
            miss_l_prev_q <= miss_l_q;
            miss_r_prev_q <= miss_r_q;
        end
    end

    assign srv_l       = (state_q == SERVE) & ~server_r_q;
    assign srv_r       = (state_q == SERVE) &  server_r_q;
    assign score_l     = score_l_q;
    assign score_r     = score_r_q;
    assign server_r    = server_r_q;
    assign point_pause = (state_q == POINT);
    assign game_over   = (state_q == GAME_OVER);
    assign winner_r    = (state_q == GAME_OVER) & (score_r_q == c_win);

endmodule
`default_nettype wire

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
- Match/serve controller sitting directly upstream of the ball block: drives its srv_l/srv_r serve strobes and consumes its miss_l/miss_r outputs.
- Tracks both scores, decides who serves next, inserts a post-point pause and declares the winner.
- Scores feed the score display; en is the same frame-rate tick the ball block uses.

Parameters:
- WIN_SCORE, 7, points needed to win; must be < 2**SCORE_W
- SCORE_W, 4, score counter width
- SERVE_HOLD, 4, en ticks srv_x stays asserted per serve
- POINT_DELAY, 60, en ticks of pause after a point
- AUTO_SERVE_TICKS, 180, en ticks before automatic serve (optional feature only)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- en  in  1  frame tick, one clk wide
- btn_l  in  1  left serve/start button, raw, asynchronous
- btn_r  in  1  right serve/start button, raw, asynchronous
- miss_l  in  1  ball passed left edge; level, held until next serve
- miss_r  in  1  ball passed right edge; level, held until next serve
- srv_l  out  1  left serve request to ball
- srv_r  out  1  right serve request to ball
- score_l  out  SCORE_W  left score
- score_r  out  SCORE_W  right score
- server_r  out  1  0 = left serves next, 1 = right
- point_pause  out  1  high during post-point pause
- game_over  out  1  match finished
- winner_r  out  1  valid with game_over; 1 = right won

Behaviour:
- Reset (reset low, async) forces:
  - state IDLE; all outputs 0; server = left; counters and edge registers cleared.
  - Reset mid-game abandons the point immediately; no partial score update.
- Buttons pass through a 2-flop synchroniser and a rising-edge detector; the edge is a 1-clk pulse, independent of en.
- miss_l/miss_r are registered; rising edges are detected on clk, since the ball holds miss high.
- Timer counter advances only on en; cleared on every state entry.
- States:
  - IDLE: any button edge -> WAIT_SERVE.
  - WAIT_SERVE: only the current server's button edge -> SERVE; the other button is ignored.
  - SERVE:
    - srv_l = !server_r, srv_r = server_r; the other srv is 0.
    - After SERVE_HOLD en ticks -> PLAY; both srv drop the same cycle.
    - Miss edges are ignored here, because the ball clears miss on serve.
  - PLAY, miss edges:
    - miss_l edge: score_r+1, server = left -> POINT.
    - miss_r edge: score_l+1, server = right -> POINT.
    - Both edges in the same cycle: no score change, server unchanged -> POINT (replay).
    - Button edges are ignored.
  - POINT: point_pause = 1; after POINT_DELAY en ticks:
    - If either score == WIN_SCORE -> GAME_OVER.
    - Otherwise -> WAIT_SERVE.
  - GAME_OVER:
    - game_over = 1; winner_r = (score_r == WIN_SCORE); scores hold.
    - Any button edge clears both scores, sets server = loser, and goes to WAIT_SERVE.
- Scores saturate at WIN_SCORE and never wrap.
- srv_l and srv_r are never high together.

Optional Feature:
- Macro: PONG_AUTO_SERVE_EN
- Defined: in WAIT_SERVE, after AUTO_SERVE_TICKS en ticks with no server button edge, go to SERVE automatically. A button edge before expiry serves immediately.
- Undefined: WAIT_SERVE waits indefinitely; parameter AUTO_SERVE_TICKS is unused.

Decomposition:
- Package pong_pkg holds:
  - typedef enum game_state_t {IDLE, WAIT_SERVE, SERVE, PLAY, POINT, GAME_OVER}
  - localparam timer width, sized for max(POINT_DELAY, AUTO_SERVE_TICKS)
- One sub-module, btn_edge: 2-flop synchroniser plus rising-edge pulse, instantiated once per button.

Test Plan:
- Reset, btn_l pulse, then btn_l again -> srv_l high for exactly 4 en ticks, srv_r stays 0, state reaches PLAY.
- In PLAY, raise miss_r and hold it -> score_l 0→1 once only; server_r = 1; point_pause high for 60 en ticks; then WAIT_SERVE. btn_l is ignored; btn_r serves via srv_r.
- miss_l and miss_r rise in the same clk -> scores unchanged, server unchanged, POINT entered.
- Drive score_r to 7 via miss_l edges -> after the pause, game_over = 1 and winner_r = 1; a further miss edge causes no change; btn_l edge clears scores to 0 and sets server = left.
- Assert reset low mid-SERVE, asynchronously between clk edges -> srv_l drops to 0 immediately; scores 0; state IDLE after release.
- With PONG_AUTO_SERVE_EN defined and no button in WAIT_SERVE -> srv asserts after 180 en ticks. With it undefined -> no srv after 500 en ticks.
